matmul_result_streamer: RTL and testbench

Drains the accumulator matrix `C[M][N]` produced by the matmul datapath onto an AXI4-Stream master interface, one element per beat, in row-major order. The block snapshots `C` on a `start` pulse so the MAC array can be cleared or reloaded while the result is being streamed. Each element is scaled and saturated to the output width. It sits between the matmul datapath/controller and the AXI output path of the accelerator.

---
 rtl/matmul_result_streamer.sv | 138 +++++++++++++
 tb/tb_matmul_result_streamer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_streamer.sv
// Streams a snapshot of the accumulator matrix C onto an AXI4-Stream master,
// row-major, one scaled and saturated element per beat.
module matmul_result_streamer #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] C [M][N],
  output logic                    busy,
  output logic                    done,
  output logic                    sat_flag,
  output logic signed [OUT_W-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(M - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  function automatic logic signed [ACC_W-1:0] shift_elem(input logic signed [ACC_W-1:0] x);
    return x >>> SHIFT;
  endfunction

  // Out of range when the bits above the output sign bit are not a pure sign extension.
  function automatic logic is_clamped(input logic signed [ACC_W-1:0] y);
    logic signed [ACC_W-1:0] hi;
    hi = y >>> (OUT_W - 1);
    return (hi != '0) && (hi != '1);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_elem(input logic signed [ACC_W-1:0] y);
    if (!is_clamped(y))
      return y[OUT_W-1:0];
    else if (y[ACC_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  state_t                  state_q, state_d;
  logic [RW-1:0]           r_q, r_d;
  logic [CW-1:0]           c_q, c_d;
  logic signed [OUT_W-1:0] tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;
  logic                    sat_q, sat_d;
  logic                    done_q, done_d;
  logic signed [ACC_W-1:0] snap_q [M][N];
  logic signed [ACC_W-1:0] snap_d [M][N];
  logic signed [ACC_W-1:0] load_y;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    snap_d  = snap_q;
    load_y  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // First beat comes straight from the live C so tvalid can rise next cycle.
          state_d = SEND;
          snap_d  = C;
          r_d     = '0;
          c_d     = '0;
          load_y  = shift_elem(C[0][0]);
          tdata_d = sat_elem(load_y);
          sat_d   = is_clamped(load_y);
          tlast_d = (M == 1) && (N == 1);
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (tlast_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            tlast_d = 1'b0;
          end else begin
            if (c_q == C_LAST) begin
              c_d = '0;
              r_d = r_q + 1'b1;
            end else begin
              c_d = c_q + 1'b1;
            end
            load_y  = shift_elem(snap_q[r_d][c_d]);
            tdata_d = sat_elem(load_y);
            sat_d   = sat_q | is_clamped(load_y);
            tlast_d = (r_d == R_LAST) && (c_d == C_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot storage is pure data and is never reset; everything visible is.
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      tdata_q <= tdata_d;
      tlast_q <= tlast_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign busy          = (state_q == SEND);
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign sat_flag      = sat_q;
  assign done          = done_q;

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Self-checking bench: two streamer instances (SHIFT=0 and SHIFT=4) checked
// against a row-major arithmetic model of scale-and-saturate.
module tb_matmul_result_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tready, start0, start4;
  logic signed [31:0] c0 [2][2];
  logic signed [31:0] c4 [2][2];
  logic busy0, done0, sat0, tv0, tl0;
  logic busy4, done4, sat4, tv4, tl4;
  logic signed [15:0] td0, td4;

  matmul_result_streamer #(.ACC_W(32), .OUT_W(16), .M(2), .N(2), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .C(c0), .busy(busy0), .done(done0),
    .sat_flag(sat0), .m_axis_tdata(td0), .m_axis_tvalid(tv0),
    .m_axis_tready(tready), .m_axis_tlast(tl0));

  matmul_result_streamer #(.ACC_W(32), .OUT_W(16), .M(2), .N(2), .SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .C(c4), .busy(busy4), .done(done4),
    .sat_flag(sat4), .m_axis_tdata(td4), .m_axis_tvalid(tv4),
    .m_axis_tready(tready), .m_axis_tlast(tl4));

  bit sel;
  wire               m_tv   = sel ? tv4 : tv0;
  wire               m_tl   = sel ? tl4 : tl0;
  wire               m_done = sel ? done4 : done0;
  wire               m_sat  = sel ? sat4 : sat0;
  wire               m_busy = sel ? busy4 : busy0;
  wire signed [15:0] m_td   = sel ? td4 : td0;

  int errors = 0;
  int checks = 0;

  int r_beats[$];
  bit r_lasts[$];
  int r_cyc[$];
  int r_done_cnt, r_done_cyc;
  bit r_unstable, r_dropped, r_tv_first, r_sat_first, r_sat_done, r_busy_done;

  int exp_q[$];
  bit exp_sat;

  // Reference: y = x >>> sh, clamped to the signed 16-bit range.
  function automatic int ref_elem(input longint x, input int sh);
    longint y;
    y = x >>> sh;
    if (y > 32767) return 32767;
    if (y < -32768) return -32768;
    return int'(y);
  endfunction

  task automatic model_frame(input bit s);
    longint x, y;
    int sh;
    sh = s ? 4 : 0;
    exp_q.delete();
    exp_sat = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        x = s ? c4[i][j] : c0[i][j];
        exp_q.push_back(ref_elem(x, sh));
        y = x >>> sh;
        if (y > 32767 || y < -32768) exp_sat = 1'b1;
      end
  endtask

  task automatic set_start(input bit v);
    if (sel) start4 = v; else start0 = v;
  endtask

  task automatic set_c(input int a, input int b, input int c, input int d);
    if (sel) c4 = '{'{a, b}, '{c, d}};
    else     c0 = '{'{a, b}, '{c, d}};
  endtask

  // Drives one frame on the selected DUT and records what the sink saw.
  task automatic run_frame(input logic [31:0] pat, input int disturb_k, input int tail,
                           input bit skip_start, input bit restart);
    int k, hs, after, prev_td;
    bit prev_stall, prev_tl, seen_done;
    r_beats.delete(); r_lasts.delete(); r_cyc.delete();
    r_done_cnt = 0; r_done_cyc = -1; r_unstable = 0; r_dropped = 0;
    r_sat_done = 0; r_busy_done = 1;
    if (!skip_start) begin
      @(negedge clk);
      set_start(1'b1);
    end
    @(negedge clk);
    set_start(1'b0);
    r_tv_first = m_tv;
    r_sat_first = m_sat;
    k = 0; hs = 0; after = 0; prev_stall = 0; prev_td = 0; prev_tl = 0; seen_done = 0;
    while (k < 200) begin
      tready = (k < 32) ? pat[k] : 1'b1;
      if (prev_stall && (!m_tv || int'(m_td) != prev_td || m_tl != prev_tl)) r_unstable = 1;
      if (!m_tv && hs > 0 && hs < 4 && !seen_done) r_dropped = 1;
      if (m_done) begin
        r_done_cnt++;
        if (!seen_done) begin
          r_done_cyc = k; r_sat_done = m_sat; r_busy_done = m_busy;
        end
        seen_done = 1;
      end
      if (m_tv && tready) begin
        r_beats.push_back(int'(m_td)); r_lasts.push_back(m_tl); r_cyc.push_back(k); hs++;
      end
      prev_stall = m_tv && !tready; prev_td = int'(m_td); prev_tl = m_tl;
      if (k == disturb_k) begin
        set_c(9, 9, 9, 9); set_start(1'b1);
      end else if (k == disturb_k + 1) begin
        set_start(1'b0);
      end
      if (seen_done) begin
        if (after == tail) begin
          if (restart) set_start(1'b1);
          break;
        end
        after++;
      end
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1; start0 = 0; start4 = 0; tready = 0; sel = 0;
    c0 = '{'{0, 0}, '{0, 0}}; c4 = '{'{0, 0}, '{0, 0}};
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, done0, sat0, tv0, tl0} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl0: got %b expected 00000", {busy0, done0, sat0, tv0, tl0});
    end
    checks++;
    if (td0 !== 16'sd0) begin
      errors++; $display("FAIL reset_tdata0: got %0d expected 0", td0);
    end
    checks++;
    if ({busy4, done4, sat4, tv4, tl4, td4} !== 21'b0) begin
      errors++; $display("FAIL reset_dut4: got %h expected 0", {busy4, done4, sat4, tv4, tl4, td4});
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 0; set_c(1, 2, 3, 4); model_frame(0);
    run_frame(32'hFFFF_FFFF, -1, 2, 0, 0);
    checks++;
    if (r_beats.size() != 4) begin
      errors++; $display("FAIL basic_count: got %0d expected 4", r_beats.size());
    end
    for (int i = 0; i < r_beats.size() && i < 4; i++) begin
      checks++;
      if (r_beats[i] != exp_q[i] || r_lasts[i] != (i == 3) || r_cyc[i] != i) begin
        errors++;
        $display("FAIL basic_beat%0d: got data=%0d last=%0b cyc=%0d expected data=%0d last=%0b cyc=%0d",
                 i, r_beats[i], r_lasts[i], r_cyc[i], exp_q[i], (i == 3), i);
      end
    end
    checks++;
    if (r_tv_first !== 1'b1) begin
      errors++; $display("FAIL basic_latency: got tvalid=%0b expected 1", r_tv_first);
    end
    checks++;
    if (r_done_cnt != 1 || r_done_cyc != 4) begin
      errors++; $display("FAIL basic_done: got count=%0d cyc=%0d expected count=1 cyc=4", r_done_cnt, r_done_cyc);
    end
    checks++;
    if (r_sat_done !== 1'b0 || r_busy_done !== 1'b0) begin
      errors++; $display("FAIL basic_flags: got sat=%0b busy=%0b expected 0 0", r_sat_done, r_busy_done);
    end
  endtask

  task automatic test_backpressure();
    int exp_cyc[4] = '{2, 4, 5, 7};
    sel = 0; set_c(1, 2, 3, 4); model_frame(0);
    run_frame(32'hFFFF_FFB4, -1, 1, 0, 0);
    checks++;
    if (r_beats.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d expected 4", r_beats.size());
    end
    for (int i = 0; i < r_beats.size() && i < 4; i++) begin
      checks++;
      if (r_beats[i] != exp_q[i] || r_cyc[i] != exp_cyc[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: got data=%0d cyc=%0d expected data=%0d cyc=%0d",
                 i, r_beats[i], r_cyc[i], exp_q[i], exp_cyc[i]);
      end
    end
    checks++;
    if (r_unstable || r_dropped) begin
      errors++; $display("FAIL bp_stable: got unstable=%0b dropped=%0b expected 0 0", r_unstable, r_dropped);
    end
    checks++;
    if (r_done_cnt != 1 || r_done_cyc != 8) begin
      errors++; $display("FAIL bp_done: got count=%0d cyc=%0d expected count=1 cyc=8", r_done_cnt, r_done_cyc);
    end
  endtask

  task automatic test_saturation();
    sel = 1; set_c(32'sh0010_0000, -32'sh0010_0000, 32'sh7F0, -32'sh7F0); model_frame(1);
    run_frame(32'hFFFF_FFFF, -1, 0, 0, 0);
    checks++;
    if (r_beats.size() != 4) begin
      errors++; $display("FAIL sat_count: got %0d expected 4", r_beats.size());
    end
    for (int i = 0; i < r_beats.size() && i < 4; i++) begin
      checks++;
      if (r_beats[i] != exp_q[i]) begin
        errors++; $display("FAIL sat_beat%0d: got %0d expected %0d", i, r_beats[i], exp_q[i]);
      end
    end
    checks++;
    if (r_sat_first !== exp_sat || r_sat_done !== exp_sat) begin
      errors++; $display("FAIL sat_flag: got first=%0b at_done=%0b expected %0b", r_sat_first, r_sat_done, exp_sat);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (sat4 !== 1'b1) begin
      errors++; $display("FAIL sat_sticky: got %0b expected 1", sat4);
    end
  endtask

  task automatic test_snapshot();
    sel = 0; set_c(1, 2, 3, 4); model_frame(0);
    run_frame(32'hFFFF_FFFF, 1, 3, 0, 0);
    checks++;
    if (r_beats.size() != 4) begin
      errors++; $display("FAIL snap_count: got %0d expected 4", r_beats.size());
    end
    for (int i = 0; i < r_beats.size() && i < 4; i++) begin
      checks++;
      if (r_beats[i] != exp_q[i]) begin
        errors++; $display("FAIL snap_beat%0d: got %0d expected %0d", i, r_beats[i], exp_q[i]);
      end
    end
    checks++;
    if (r_done_cnt != 1 || tv0 !== 1'b0) begin
      errors++; $display("FAIL snap_done: got count=%0d tvalid=%0b expected count=1 tvalid=0", r_done_cnt, tv0);
    end
    set_c(1, 2, 3, 4);
  endtask

  task automatic test_back_to_back();
    int a_beats[$];
    int a_exp[$];
    int a_done;
    sel = 1; set_c(32'sh0010_0000, -32'sh0010_0000, 32'sh7F0, -32'sh7F0); model_frame(1);
    a_exp = exp_q;
    run_frame(32'hFFFF_FFFF, -1, 0, 0, 1);
    a_beats = r_beats; a_done = r_done_cnt;
    set_c(16, 32, 48, 64); model_frame(1);
    run_frame(32'hFFFF_FFFF, -1, 1, 1, 0);
    checks++;
    if (a_beats != a_exp || a_done != 1) begin
      errors++; $display("FAIL b2b_first: got %p done=%0d expected %p done=1", a_beats, a_done, a_exp);
    end
    checks++;
    if (r_tv_first !== 1'b1 || r_sat_first !== 1'b0) begin
      errors++; $display("FAIL b2b_restart: got tvalid=%0b sat=%0b expected 1 0", r_tv_first, r_sat_first);
    end
    checks++;
    if (r_beats != exp_q || r_done_cnt != 1) begin
      errors++; $display("FAIL b2b_second: got %p done=%0d expected %p done=1", r_beats, r_done_cnt, exp_q);
    end
  endtask

  task automatic test_reset_midframe();
    bit spurious;
    sel = 1; set_c(32'sh0010_0000, -32'sh0010_0000, 32'sh7F0, -32'sh7F0); model_frame(1);
    @(negedge clk); start4 = 1; tready = 1;
    @(negedge clk); start4 = 0;
    @(negedge clk);
    @(negedge clk); tready = 0; rst = 1;
    @(negedge clk);
    checks++;
    if ({busy4, done4, sat4, tv4, tl4} !== 5'b0 || td4 !== 16'sd0) begin
      errors++; $display("FAIL rstmid_outputs: got ctrl=%b data=%0d expected 00000 0",
                         {busy4, done4, sat4, tv4, tl4}, td4);
    end
    rst = 0; spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (done4 || tv4) spurious = 1;
    end
    checks++;
    if (spurious) begin
      errors++; $display("FAIL rstmid_quiet: got activity=1 expected 0");
    end
    run_frame(32'hFFFF_FFFF, -1, 0, 0, 0);
    checks++;
    if (r_beats != exp_q || r_done_cnt != 1 || r_sat_done != exp_sat) begin
      errors++; $display("FAIL rstmid_fresh: got %p done=%0d sat=%0b expected %p done=1 sat=%0b",
                         r_beats, r_done_cnt, r_sat_done, exp_q, exp_sat);
    end
  endtask

  task automatic test_random();
    int v[4];
    for (int f = 0; f < 8; f++) begin
      sel = f[0];
      for (int i = 0; i < 4; i++)
        v[i] = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 1200000)) - 600000;
      set_c(v[0], v[1], v[2], v[3]); model_frame(sel);
      run_frame($urandom, -1, 0, 0, 0);
      checks++;
      if (r_beats != exp_q) begin
        errors++; $display("FAIL rand%0d_data: got %p expected %p", f, r_beats, exp_q);
      end
      checks++;
      if (r_lasts.size() != 4 || r_lasts[3] != 1'b1 || r_lasts[0] | r_lasts[1] | r_lasts[2]) begin
        errors++; $display("FAIL rand%0d_last: got %p expected '{0,0,0,1}", f, r_lasts);
      end
      checks++;
      if (r_done_cnt != 1 || r_unstable || r_dropped || r_sat_done != exp_sat) begin
        errors++; $display("FAIL rand%0d_ctrl: got done=%0d unstable=%0b dropped=%0b sat=%0b expected 1 0 0 %0b",
                           f, r_done_cnt, r_unstable, r_dropped, r_sat_done, exp_sat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_snapshot();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
